// File: rtl/frame_loader_pkg.sv
// Shared definitions for the frame loader and the parallel register bank it feeds.
package frame_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;
    localparam int         BANK_DEPTH  = 15;
    localparam int         BYTE_W      = 8;

    function automatic logic [BYTE_W-1:0] csum_update(
        input logic [BYTE_W-1:0] acc,
        input logic [BYTE_W-1:0] b
    );
        return acc ^ b;
    endfunction

endpackage

// File: rtl/frame_loader_interbyte_timer.sv
// Inter-byte gap counter: restarts on every byte, flags expiry when the gap
// reaches TIMEOUT_CYC-1 counted cycles with no byte arriving.
module frame_loader_interbyte_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic mclk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc_s;

    assign cnt_inc_s = cnt_q + CNT_W'(1);
    // A byte in the expiry cycle wins over the timeout.
    assign expire    = en & ~clr & (cnt_inc_s == LAST);

    // Next count: cleared when idle or on a byte, saturating at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_inc_s;
        end
    end

    // Counter register.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_loader.sv
// Frame loader: parses SOF + payload + XOR checksum frames from the byte
// receiver and writes each payload byte into the parallel register bank.
module frame_loader
    import frame_loader_pkg::*;
#(
    parameter int                NUM_BYTES   = BANK_DEPTH,
    parameter logic [BYTE_W-1:0] SOF         = SOF_DEFAULT,
    parameter int                TIMEOUT_CYC = 1000
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [BYTE_W-1:0] data_in,
    output logic [3:0]        use_dw,
    output logic              wr,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES - 1);

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [BYTE_W-1:0] acc_q, acc_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic [3:0]        use_dw_q, use_dw_d;
    logic              wr_q, wr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              timer_en_s;
    logic              expire_s;

    assign timer_en_s = (state_q != IDLE);

    frame_loader_interbyte_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .mclk  (mclk),
        .reset (reset),
        .en    (timer_en_s),
        .clr   (rx_valid),
        .expire(expire_s)
    );

    // Next-state and next-output logic for the frame parser.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        data_d   = data_q;
        use_dw_d = use_dw_q;
        wr_d     = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid && (rx_data == SOF)) begin
                    state_d = PAYLOAD;
                    idx_d   = 4'd0;
                    acc_d   = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    wr_d     = 1'b1;
                    data_d   = rx_data;
                    use_dw_d = idx_q;
                    acc_d    = csum_update(acc_q, rx_data);
                    if (idx_q == LAST_IDX) begin
                        state_d = CHECK;
                        idx_d   = 4'd0;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                    end
                end else if (expire_s) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = PAYLOAD;
                end
            end
            CHECK: begin
                if (rx_valid) begin
                    if (rx_data == acc_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                    end
                    state_d = IDLE;
                end else if (expire_s) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = CHECK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, bookkeeping and registered outputs.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= 4'd0;
            acc_q    <= 8'd0;
            data_q   <= 8'd0;
            use_dw_q <= 4'd0;
            wr_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            data_q   <= data_d;
            use_dw_q <= use_dw_d;
            wr_q     <= wr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign data_in    = data_q;
    assign use_dw     = use_dw_q;
    assign wr         = wr_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader: a vector table for a full-rate frame plus
// hand-written sequences for spaced frames, bad checksum, timeout and reset.
module tb_frame_loader;

    localparam int TO = 1000;

    logic       mclk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic [7:0] data_in;
    logic [3:0] use_dw;
    logic       wr;
    logic       busy;
    logic       frame_done;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] payload [15] = '{8'h45, 8'h87, 8'h2E, 8'h6D, 8'hF2, 8'hDA, 8'hEA, 8'h9E,
                                 8'h3A, 8'hEF, 8'hE3, 8'hD4, 8'hAB, 8'hFE, 8'hFF};
    localparam logic [119:0] BUS_EXP = 120'hFFFEABD4E3EF3A9EEADAF26D2E8745;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       e_wr;
        logic [3:0] e_idx;
        logic [7:0] e_data;
        logic       e_busy;
        logic       e_done;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    logic [119:0] bank = '0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    always #5 mclk = ~mclk;

    frame_loader #(
        .NUM_BYTES  (15),
        .SOF        (8'hA5),
        .TIMEOUT_CYC(TO)
    ) dut (
        .mclk      (mclk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .data_in   (data_in),
        .use_dw    (use_dw),
        .wr        (wr),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_err (frame_err)
    );

    // Register-bank model and pulse counters, sampled mid-cycle.
    always @(negedge mclk) begin
        if (wr) begin
            if (use_dw < 4'd15) bank[use_dw*8 +: 8] <= data_in;
            wr_cnt <= wr_cnt + 1;
        end
        if (frame_done) done_cnt <= done_cnt + 1;
        if (frame_err)  err_cnt  <= err_cnt + 1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        rx_valid = 1'b1;
        rx_data  = d;
        @(posedge mclk);
        #1;
        rx_valid = 1'b0;
        idle(gap);
    endtask

    task automatic send_frame(input logic [7:0] ck, input int gap);
        send(8'hA5, gap);
        for (int i = 0; i < 15; i++) send(payload[i], gap);
        send(ck, gap);
    endtask

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic w,
                                input logic [3:0] ix, input logic [7:0] dt,
                                input logic b, input logic dn, input logic er);
        vec_t r;
        r.v = v; r.d = d; r.e_wr = w; r.e_idx = ix; r.e_data = dt;
        r.e_busy = b; r.e_done = dn; r.e_err = er;
        return r;
    endfunction

    initial begin
        int w0, d0, e0, cyc;
        vec_t t;

        // Full-rate frame preceded by IDLE noise.
        vecs.push_back(mk(1'b1, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 8'hFF, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 8'h5A, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 8'hA5, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 15; i++)
            vecs.push_back(mk(1'b1, payload[i], 1'b1, 4'(i), payload[i], 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 8'h95, 1'b0, 4'd14, 8'hFF, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 4'd14, 8'hFF, 1'b0, 1'b0, 1'b0));

        idle(3);
        chk("reset_outputs", {wr, use_dw, data_in, busy, frame_done, frame_err}, 16'h0000);
        reset = 1'b1;
        idle(2);

        foreach (vecs[i]) begin
            t = vecs[i];
            rx_valid = t.v;
            rx_data  = t.d;
            @(posedge mclk);
            #1;
            rx_valid = 1'b0;
            chk($sformatf("vec%0d", i), {wr, use_dw, data_in, busy, frame_done, frame_err},
                {t.e_wr, t.e_idx, t.e_data, t.e_busy, t.e_done, t.e_err});
        end
        idle(2);
        chk("burst_bus", bank, BUS_EXP);
        chk("burst_wr_count", wr_cnt, 15);

        // Nominal frame, one byte every 20 cycles.
        bank = '0;
        w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h95, 19);
        chk("nominal_wr", wr_cnt - w0, 15);
        chk("nominal_done", done_cnt - d0, 1);
        chk("nominal_err", err_cnt - e0, 0);
        chk("nominal_bus", bank, BUS_EXP);

        // Bad checksum.
        w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h94, 19);
        chk("badck_wr", wr_cnt - w0, 15);
        chk("badck_err", err_cnt - e0, 1);
        chk("badck_done", done_cnt - d0, 0);
        chk("badck_busy", busy, 1'b0);

        // Timeout after A5 45 87.
        e0 = err_cnt;
        send(8'hA5, 0);
        send(8'h45, 0);
        send(8'h87, 0);
        cyc = 1;
        while (!frame_err && cyc < TO + 50) begin
            @(posedge mclk);
            #1;
            cyc++;
        end
        chk("timeout_latency", cyc, TO);
        chk("timeout_busy", busy, 1'b0);
        idle(2);
        chk("timeout_err_once", err_cnt - e0, 1);
        w0 = wr_cnt; d0 = done_cnt;
        send_frame(8'h95, 0);
        idle(2);
        chk("after_timeout_wr", wr_cnt - w0, 15);
        chk("after_timeout_done", done_cnt - d0, 1);

        // Byte delivered exactly in the timeout-expiry cycle.
        d0 = done_cnt; e0 = err_cnt;
        send(8'hA5, 0);
        send(8'h45, 0);
        idle(TO - 2);
        for (int i = 1; i < 15; i++) send(payload[i], 0);
        send(8'h95, 0);
        idle(2);
        chk("edge_done", done_cnt - d0, 1);
        chk("edge_err", err_cnt - e0, 0);

        // Reset after payload byte 7.
        e0 = err_cnt;
        bank = '0;
        send(8'hA5, 0);
        for (int i = 0; i < 8; i++) send(payload[i], 0);
        reset = 1'b0;
        #1;
        chk("midreset_outputs", {wr, use_dw, data_in, busy, frame_done, frame_err}, 16'h0000);
        idle(2);
        reset = 1'b1;
        idle(1);
        chk("midreset_err", err_cnt - e0, 0);
        w0 = wr_cnt; d0 = done_cnt;
        send_frame(8'h95, 0);
        idle(2);
        chk("postreset_wr", wr_cnt - w0, 15);
        chk("postreset_done", done_cnt - d0, 1);
        chk("postreset_bus", bank, BUS_EXP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
